manta_bus_arbiter: RTL and testbench

- Shares one Manta core-chain bus (16-bit addr/data, rw, valid pulse) between two requesters.
  - Port A: host bridge, UART receive side.
  - Port B: on-chip requester, e.g. an autonomous poller.
- Issues one transaction per cycle onto the chain head.
- Tracks outstanding reads in a tag FIFO and steers each read response from the chain tail back to the requester that issued it.
- Sits between bridge_rx / the poller and the first core; the chain tail feeds it back, and the A response goes to bridge_tx.

---
 rtl/manta_bus_arbiter.sv | 147 ++++++++++++++
 tb/tb_manta_bus_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/manta_bus_arbiter.sv
// manta_bus_arbiter: shares the Manta chain head between host bridge (A) and on-chip requester (B), routing read responses by tag.
// Define MANTA_ARB_HOST_PRIORITY_EN for fixed A priority; otherwise round-robin.
module manta_bus_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int TAG_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_W-1:0]            a_addr_i,
    input  logic [DATA_W-1:0]            a_data_i,
    input  logic                         a_rw_i,
    input  logic                         a_valid_i,
    input  logic [ADDR_W-1:0]            b_addr_i,
    input  logic [DATA_W-1:0]            b_data_i,
    input  logic                         b_rw_i,
    input  logic                         b_valid_i,
    output logic [ADDR_W-1:0]            bus_addr_o,
    output logic [DATA_W-1:0]            bus_data_o,
    output logic                         bus_rw_o,
    output logic                         bus_valid_o,
    input  logic [DATA_W-1:0]            resp_data_i,
    input  logic                         resp_rw_i,
    input  logic                         resp_valid_i,
    output logic [DATA_W-1:0]            a_resp_data_o,
    output logic                         a_resp_rw_o,
    output logic                         a_resp_valid_o,
    output logic [DATA_W-1:0]            b_resp_data_o,
    output logic                         b_resp_valid_o,
    output logic                         a_drop_o,
    output logic                         b_drop_o,
    output logic                         orphan_o,
    output logic [$clog2(TAG_DEPTH):0]   outstanding_o
);
    localparam int PW = $clog2(TAG_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(TAG_DEPTH);

    typedef struct packed {
        logic              v;
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    req_t a_q, a_d, b_q, b_d, bus_q, bus_d;
    logic [TAG_DEPTH-1:0] ids_q, ids_d;
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] a_rd_q, a_rd_d, b_rd_q, b_rd_d;
    logic a_rv_q, a_rv_d, b_rv_q, b_rv_d;
    logic a_drop_q, a_drop_d, b_drop_q, b_drop_d, orph_q, orph_d;
    logic el_a, el_b, gnt_a, gnt_b, push, rd, pop;
`ifndef MANTA_ARB_HOST_PRIORITY_EN
    logic last_q, last_d;
`endif

    always_comb begin
        el_a = a_q.v && (a_q.rw || cnt_q < FULL);
        el_b = b_q.v && (b_q.rw || cnt_q < FULL);
`ifdef MANTA_ARB_HOST_PRIORITY_EN
        gnt_a = el_a;
        gnt_b = el_b && !gnt_a;
`else
        // last_q=1 means B was served last, so A wins a tie
        gnt_a = el_a && (!el_b || last_q);
        gnt_b = el_b && !gnt_a;
        last_d = gnt_a ? 1'b0 : (gnt_b ? 1'b1 : last_q);
`endif
        a_drop_d = a_drop_q || (a_valid_i && a_q.v && !gnt_a);
        b_drop_d = b_drop_q || (b_valid_i && b_q.v && !gnt_b);
        a_d = a_q;
        a_d.v = a_q.v && !gnt_a;
        if (a_valid_i && !a_d.v) a_d = '{v: 1'b1, rw: a_rw_i, addr: a_addr_i, data: a_data_i};
        b_d = b_q;
        b_d.v = b_q.v && !gnt_b;
        if (b_valid_i && !b_d.v) b_d = '{v: 1'b1, rw: b_rw_i, addr: b_addr_i, data: b_data_i};
        bus_d = gnt_a ? a_q : (gnt_b ? b_q : '0);
        push = bus_d.v && !bus_d.rw;
        rd = resp_valid_i && !resp_rw_i;
        pop = rd && cnt_q != '0;
        orph_d = orph_q || (rd && cnt_q == '0);
        ids_d = ids_q;
        if (push) ids_d[wp_q] = gnt_b;
        wp_d = wp_q + PW'(push);
        rp_d = rp_q + PW'(pop);
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        a_rv_d = pop && !ids_q[rp_q];
        b_rv_d = pop && ids_q[rp_q];
        a_rd_d = a_rv_d ? resp_data_i : '0;
        b_rd_d = b_rv_d ? resp_data_i : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            bus_q    <= '0;
            ids_q    <= '0;
            wp_q     <= '0;
            rp_q     <= '0;
            cnt_q    <= '0;
            a_rv_q   <= 1'b0;
            b_rv_q   <= 1'b0;
            a_rd_q   <= '0;
            b_rd_q   <= '0;
            a_drop_q <= 1'b0;
            b_drop_q <= 1'b0;
            orph_q   <= 1'b0;
`ifndef MANTA_ARB_HOST_PRIORITY_EN
            last_q   <= 1'b1;
`endif
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            bus_q    <= bus_d;
            ids_q    <= ids_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            cnt_q    <= cnt_d;
            a_rv_q   <= a_rv_d;
            b_rv_q   <= b_rv_d;
            a_rd_q   <= a_rd_d;
            b_rd_q   <= b_rd_d;
            a_drop_q <= a_drop_d;
            b_drop_q <= b_drop_d;
            orph_q   <= orph_d;
`ifndef MANTA_ARB_HOST_PRIORITY_EN
            last_q   <= last_d;
`endif
        end
    end

    assign bus_addr_o     = bus_q.addr;
    assign bus_data_o     = bus_q.data;
    assign bus_rw_o       = bus_q.rw;
    assign bus_valid_o    = bus_q.v;
    assign a_resp_data_o  = a_rd_q;
    assign a_resp_rw_o    = 1'b0;
    assign a_resp_valid_o = a_rv_q;
    assign b_resp_data_o  = b_rd_q;
    assign b_resp_valid_o = b_rv_q;
    assign a_drop_o       = a_drop_q;
    assign b_drop_o       = b_drop_q;
    assign orphan_o       = orph_q;
    assign outstanding_o  = cnt_q;
endmodule

// File: tb/tb_manta_bus_arbiter.sv
// tb_manta_bus_arbiter: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_manta_bus_arbiter;
    localparam int TD = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [15:0] a_addr_i, a_data_i, b_addr_i, b_data_i, resp_data_i;
    logic a_rw_i, a_valid_i, b_rw_i, b_valid_i, resp_rw_i, resp_valid_i;
    logic [15:0] bus_addr_o, bus_data_o, a_resp_data_o, b_resp_data_o;
    logic bus_rw_o, bus_valid_o, a_resp_rw_o, a_resp_valid_o, b_resp_valid_o;
    logic a_drop_o, b_drop_o, orphan_o;
    logic [2:0] outstanding_o;

    int errors = 0;
    int checks = 0;

    manta_bus_arbiter #(.ADDR_W(16), .DATA_W(16), .TAG_DEPTH(TD)) dut (
        .clk(clk), .rst(rst),
        .a_addr_i(a_addr_i), .a_data_i(a_data_i), .a_rw_i(a_rw_i), .a_valid_i(a_valid_i),
        .b_addr_i(b_addr_i), .b_data_i(b_data_i), .b_rw_i(b_rw_i), .b_valid_i(b_valid_i),
        .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o), .bus_rw_o(bus_rw_o), .bus_valid_o(bus_valid_o),
        .resp_data_i(resp_data_i), .resp_rw_i(resp_rw_i), .resp_valid_i(resp_valid_i),
        .a_resp_data_o(a_resp_data_o), .a_resp_rw_o(a_resp_rw_o), .a_resp_valid_o(a_resp_valid_o),
        .b_resp_data_o(b_resp_data_o), .b_resp_valid_o(b_resp_valid_o),
        .a_drop_o(a_drop_o), .b_drop_o(b_drop_o), .orphan_o(orphan_o),
        .outstanding_o(outstanding_o)
    );

    always #5 clk = ~clk;

    // Reference model: holds as plain arrays, outstanding reads as a queue of requester IDs.
    logic        m_hv[2], m_hrw[2], m_drop[2];
    logic [15:0] m_ha[2], m_hd[2];
    logic        m_last;
    bit          m_tags[$];
    logic        m_bv, m_brw, m_arv, m_brv, m_orph;
    logic [15:0] m_ba, m_bd, m_ard, m_brd;

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_hv[p] = 0; m_hrw[p] = 0; m_drop[p] = 0; m_ha[p] = 0; m_hd[p] = 0;
        end
        m_last = 1;
        m_tags.delete();
        {m_bv, m_brw, m_arv, m_brv, m_orph} = '0;
        {m_ba, m_bd, m_ard, m_brd} = '0;
    endtask

    task automatic model_step();
        logic el[2];
        logic vin[2], rwin[2];
        logic [15:0] ain[2], din[2];
        int g;
        bit id;
        vin[0] = a_valid_i; rwin[0] = a_rw_i; ain[0] = a_addr_i; din[0] = a_data_i;
        vin[1] = b_valid_i; rwin[1] = b_rw_i; ain[1] = b_addr_i; din[1] = b_data_i;
        for (int p = 0; p < 2; p++) el[p] = m_hv[p] && (m_hrw[p] || m_tags.size() < TD);
        g = -1;
`ifdef MANTA_ARB_HOST_PRIORITY_EN
        if (el[0]) g = 0;
        else if (el[1]) g = 1;
`else
        if (el[0] && el[1]) g = m_last ? 0 : 1;
        else if (el[0]) g = 0;
        else if (el[1]) g = 1;
`endif
        m_arv = 0; m_brv = 0; m_ard = 0; m_brd = 0;
        if (resp_valid_i && !resp_rw_i) begin
            if (m_tags.size() == 0) m_orph = 1;
            else begin
                id = m_tags.pop_front();
                if (id) begin m_brv = 1; m_brd = resp_data_i; end
                else begin m_arv = 1; m_ard = resp_data_i; end
            end
        end
        m_bv = 0; m_ba = 0; m_bd = 0; m_brw = 0;
        if (g >= 0) begin
            m_bv = 1; m_ba = m_ha[g]; m_bd = m_hd[g]; m_brw = m_hrw[g];
            if (!m_hrw[g]) m_tags.push_back(g == 1);
            m_hv[g] = 0;
            m_last = (g == 1);
        end
        for (int p = 0; p < 2; p++)
            if (vin[p]) begin
                if (m_hv[p]) m_drop[p] = 1;
                else begin m_hv[p] = 1; m_ha[p] = ain[p]; m_hd[p] = din[p]; m_hrw[p] = rwin[p]; end
            end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else model_step();
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("bus_valid", 32'(bus_valid_o), 32'(m_bv));
        chk("bus_addr", 32'(bus_addr_o), 32'(m_ba));
        chk("bus_data", 32'(bus_data_o), 32'(m_bd));
        chk("bus_rw", 32'(bus_rw_o), 32'(m_brw));
        chk("a_resp_valid", 32'(a_resp_valid_o), 32'(m_arv));
        if (m_arv) chk("a_resp_data", 32'(a_resp_data_o), 32'(m_ard));
        chk("a_resp_rw", 32'(a_resp_rw_o), 32'd0);
        chk("b_resp_valid", 32'(b_resp_valid_o), 32'(m_brv));
        if (m_brv) chk("b_resp_data", 32'(b_resp_data_o), 32'(m_brd));
        chk("a_drop", 32'(a_drop_o), 32'(m_drop[0]));
        chk("b_drop", 32'(b_drop_o), 32'(m_drop[1]));
        chk("orphan", 32'(orphan_o), 32'(m_orph));
        chk("outstanding", 32'(outstanding_o), 32'(m_tags.size()));
    endtask

    task automatic drv_a(input logic v, input logic [15:0] ad, input logic [15:0] d, input logic rw);
        a_valid_i = v; a_addr_i = ad; a_data_i = d; a_rw_i = rw;
    endtask

    task automatic drv_b(input logic v, input logic [15:0] ad, input logic [15:0] d, input logic rw);
        b_valid_i = v; b_addr_i = ad; b_data_i = d; b_rw_i = rw;
    endtask

    task automatic drv_r(input logic v, input logic rw, input logic [15:0] d);
        resp_valid_i = v; resp_rw_i = rw; resp_data_i = d;
    endtask

    task automatic idle();
        drv_a(0, 0, 0, 0);
        drv_b(0, 0, 0, 0);
        drv_r(0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        idle();
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit seq[$];
        int due[$];
        int viol;
        int pa, pb, pr, pw;
        idle();
        #1 rst = 1;
        fork
            forever begin
                @(negedge clk);
                if (!rst) compare_all();
            end
        join_none
        repeat (2) @(negedge clk);
        rst = 0;
        chk("reset_outstanding", 32'(outstanding_o), 32'd0);
        chk("reset_bus_valid", 32'(bus_valid_o), 32'd0);
        chk("reset_flags", 32'({a_drop_o, b_drop_o, orphan_o}), 32'd0);

        // single A read
        drv_a(1, 16'h0003, 16'h0000, 0);
        @(negedge clk); idle();
        @(negedge clk);
        chk("t1_bus_valid", 32'(bus_valid_o), 32'd1);
        chk("t1_bus_addr", 32'(bus_addr_o), 32'h0003);
        chk("t1_bus_rw", 32'(bus_rw_o), 32'd0);
        chk("t1_outstanding", 32'(outstanding_o), 32'd1);
        drv_r(1, 0, 16'h1234);
        @(negedge clk); idle();
        chk("t1_a_resp_valid", 32'(a_resp_valid_o), 32'd1);
        chk("t1_a_resp_data", 32'(a_resp_data_o), 32'h1234);
        chk("t1_b_resp_valid", 32'(b_resp_valid_o), 32'd0);
        chk("t1_bus_idle", 32'(bus_valid_o), 32'd0);

        // A write and B read on the same edge
        do_reset();
        drv_a(1, 16'h0005, 16'hBEEF, 1);
        drv_b(1, 16'h0001, 16'h0000, 0);
        @(negedge clk); idle();
        @(negedge clk);
        chk("t2_first_addr", 32'({bus_valid_o, bus_rw_o, bus_addr_o}), 32'h30005);
        chk("t2_first_data", 32'(bus_data_o), 32'hBEEF);
        @(negedge clk);
        chk("t2_second_addr", 32'({bus_valid_o, bus_rw_o, bus_addr_o}), 32'h20001);
        chk("t2_outstanding1", 32'(outstanding_o), 32'd1);
        drv_r(1, 0, 16'h55AA);
        @(negedge clk); idle();
        chk("t2_b_resp", 32'({b_resp_valid_o, b_resp_data_o}), 32'h155AA);
        chk("t2_a_resp_valid", 32'(a_resp_valid_o), 32'd0);
        chk("t2_outstanding0", 32'(outstanding_o), 32'd0);

        // continuous reads from both ports, tail answers 3 cycles after issue
        do_reset();
        for (int c = 0; c < 30; c++) begin
            drv_a(1, 16'hA000 + 16'(c), 0, 0);
            drv_b(1, 16'hB000 + 16'(c), 0, 0);
            if (due.size() > 0 && due[0] == c) begin
                void'(due.pop_front());
                drv_r(1, 0, 16'($urandom));
            end else drv_r(0, 0, 0);
            @(negedge clk);
            if (bus_valid_o && !bus_rw_o) begin
                seq.push_back(bus_addr_o[15:12] == 4'hB);
                due.push_back(c + 3);
            end
        end
        idle();
        viol = 0;
        for (int i = 0; i < seq.size(); i++) begin
`ifdef MANTA_ARB_HOST_PRIORITY_EN
            if (seq[i]) viol++;
`else
            if (seq[i] != (i % 2 == 1)) viol++;
`endif
        end
        chk("t3_issue_count", 32'(seq.size() >= 10), 32'd1);
        chk("t3_grant_order", 32'(viol), 32'd0);

        // tag FIFO full, then hold full, then freed slot
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drv_b(1, 16'(i), 0, 0);
            @(negedge clk);
        end
        idle();
        @(negedge clk);
        chk("t4_full_outstanding", 32'(outstanding_o), 32'd4);
        chk("t4_full_no_issue", 32'(bus_valid_o), 32'd0);
        chk("t4_no_drop_yet", 32'(b_drop_o), 32'd0);
        drv_b(1, 16'h0009, 0, 0);
        @(negedge clk); idle();
        chk("t4_drop", 32'(b_drop_o), 32'd1);
        chk("t4_still_full", 32'(outstanding_o), 32'd4);
        drv_r(1, 0, 16'h0BEE);
        @(negedge clk); idle();
        chk("t4_after_pop", 32'(outstanding_o), 32'd3);
        chk("t4_not_yet", 32'(bus_valid_o), 32'd0);
        chk("t4_b_resp", 32'({b_resp_valid_o, b_resp_data_o}), 32'h10BEE);
        @(negedge clk);
        chk("t4_fifth_issue", 32'({bus_valid_o, bus_addr_o}), 32'h10004);
        chk("t4_refill", 32'(outstanding_o), 32'd4);

        // write echo ignored, read with empty FIFO is an orphan
        do_reset();
        drv_r(1, 1, 16'h7777);
        @(negedge clk); idle();
        chk("t5_echo_orphan", 32'(orphan_o), 32'd0);
        chk("t5_echo_resp", 32'({a_resp_valid_o, b_resp_valid_o}), 32'd0);
        drv_r(1, 0, 16'h7777);
        @(negedge clk); idle();
        chk("t5_orphan", 32'(orphan_o), 32'd1);
        chk("t5_orphan_resp", 32'({a_resp_valid_o, b_resp_valid_o}), 32'd0);

        // asynchronous reset with two reads outstanding
        do_reset();
        drv_a(1, 16'h0010, 0, 0);
        @(negedge clk);
        drv_a(1, 16'h0011, 0, 0);
        @(negedge clk); idle();
        chk("t6_one_out", 32'(outstanding_o), 32'd1);
        @(posedge clk);
        #2;
        chk("t6_pre_reset", 32'({bus_valid_o, outstanding_o}), 32'hA);
        rst = 1;
        #1;
        chk("t6_bus_cleared", 32'({bus_valid_o, bus_rw_o, bus_addr_o, bus_data_o}), 32'd0);
        chk("t6_out_cleared", 32'(outstanding_o), 32'd0);
        chk("t6_flags_cleared", 32'({a_drop_o, b_drop_o, orphan_o, a_resp_valid_o, b_resp_valid_o}), 32'd0);
        @(negedge clk);
        rst = 0;
        drv_r(1, 0, 16'h0001);
        @(negedge clk); idle();
        chk("t6_late_orphan", 32'(orphan_o), 32'd1);
        chk("t6_late_no_resp", 32'({a_resp_valid_o, b_resp_valid_o}), 32'd0);

        // randomized traffic, checked every cycle by the compare process
        for (int s = 0; s < 6; s++) begin
            do_reset();
            pa = $urandom_range(10, 90);
            pb = $urandom_range(10, 90);
            pr = $urandom_range(10, 70);
            pw = $urandom_range(0, 60);
            for (int c = 0; c < 500; c++) begin
                drv_a($urandom_range(0, 99) < pa, 16'($urandom), 16'($urandom), $urandom_range(0, 99) < pw);
                drv_b($urandom_range(0, 99) < pb, 16'($urandom), 16'($urandom), $urandom_range(0, 99) < pw);
                drv_r($urandom_range(0, 99) < pr, $urandom_range(0, 3) == 0, 16'($urandom));
                @(negedge clk);
            end
        end
        idle();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
